// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution engine host.
//   DW / AW / L1_AW : data width, image/layer-0 address width, layer-1 address width
//   CSEL_L0/CSEL_L1 : engine memory-select codes
//   state_t         : host sequencer states
package conv_pkg;

  localparam int DW    = 20;
  localparam int AW    = 12;
  localparam int L1_AW = 10;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/conv_host_ram.sv
// conv_host_ram: simple 2^ABITS x WIDTH memory.
//   clk, reset         : clock; reset clears only the readback register
//   we/waddr/wdata     : single write port
//   raddr -> rdata     : asynchronous read port
//   rb_en/rb_addr      : readback request, sampled on the rising edge
//   rb_data            : registered readback word, held while rb_en is low
module conv_host_ram
  import conv_pkg::*;
#(
  parameter int ABITS = AW,
  parameter int WIDTH = DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic             rb_en,
  input  logic [ABITS-1:0] rb_addr,
  output logic [WIDTH-1:0] rb_data
);

  localparam int DEPTH = 1 << ABITS;

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset so data survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (reset)      rb_data <= '0;
    else if (rb_en) rb_data <= mem[rb_addr];
  end

endmodule

// File: rtl/conv_host.sv
// conv_host: host-side responder for the convolution engine.
//   start, ld_valid/ld_data/ld_ready : run request and raster image stream
//   ready, busy                      : engine start pulse / engine busy
//   iaddr -> idata                   : combinational image read
//   cwr/caddr_wr/cdata_wr            : engine layer writes (csel chooses L0/L1)
//   crd/caddr_rd -> cdata_rd         : combinational engine layer reads
//   rb_sel/rb_addr -> rb_data        : registered result readback in DONE
//   done, timeout, proto_err         : run status (timeout/proto_err sticky)
//   l0_wr_cnt, l1_wr_cnt             : saturating per-run write counts
module conv_host
  import conv_pkg::*;
#(
  parameter logic [31:0] MAX_CYC = 32'd2000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic          rb_sel,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  output logic          done,
  output logic          timeout,
  output logic          proto_err,
  output logic [12:0]   l0_wr_cnt,
  output logic [10:0]   l1_wr_cnt
);

  state_t state_q, state_d;

  logic [AW-1:0] ld_cnt;
  logic [31:0]   cyc_cnt;
  logic          busy_seen;
  logic          rb_sel_q;
  logic          rb_en;

  logic in_run, start_ok, ld_fire, ld_last, run_end, wd_hit;
  logic sel_l0, sel_l1, wr_l0, wr_l1, l0_sat, l1_sat, proto_set;

  logic [DW-1:0] l0_rdata, l1_rdata, l0_rb, l1_rb, img_rb_unused;

  assign in_run   = (state_q == ST_RUN);
  assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign ld_fire  = ld_valid & ld_ready;
  assign ld_last  = ld_fire & (ld_cnt == '1);
  assign run_end  = busy_seen & ~busy;
  // Normal completion wins over the watchdog when both happen on one edge.
  assign wd_hit   = (cyc_cnt == MAX_CYC - 32'd1) & ~run_end;

  assign sel_l0 = (csel == CSEL_L0);
  assign sel_l1 = (csel == CSEL_L1);
  assign wr_l0  = in_run & cwr & sel_l0;
  assign wr_l1  = in_run & cwr & sel_l1;
  assign l0_sat = (l0_wr_cnt == 13'd4096);
  assign l1_sat = (l1_wr_cnt == 11'd1024);

  // Illegal accesses only flag an error; legal-select writes still land.
  assign proto_set = ((cwr | crd) & ~in_run)
                   | (in_run & cwr & ~sel_l0 & ~sel_l1)
                   | (in_run & cwr & crd)
                   | (wr_l1 & (|caddr_wr[AW-1:L1_AW]))
                   | (wr_l0 & l0_sat)
                   | (wr_l1 & l1_sat);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_LOAD;
      ST_LOAD:  if (ld_last) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (run_end | wd_hit) state_d = ST_DONE;
      ST_DONE:  if (start_ok) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_ready = (state_q == ST_LOAD);
    ready    = (state_q == ST_START);
    done     = (state_q == ST_DONE);
    rb_en    = (state_q == ST_DONE);
  end

  // Run bookkeeping; a new run request wipes all per-run status.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt    <= '0;
      cyc_cnt   <= '0;
      busy_seen <= 1'b0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
      l0_wr_cnt <= '0;
      l1_wr_cnt <= '0;
      rb_sel_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        ld_cnt    <= '0;
        cyc_cnt   <= '0;
        busy_seen <= 1'b0;
        timeout   <= 1'b0;
        proto_err <= 1'b0;
        l0_wr_cnt <= '0;
        l1_wr_cnt <= '0;
      end else begin
        if (ld_fire) ld_cnt <= ld_cnt + AW'(1);
        if (in_run) begin
          cyc_cnt <= cyc_cnt + 32'd1;
          if (busy)   busy_seen <= 1'b1;
          if (wd_hit) timeout   <= 1'b1;
        end
        if (wr_l0 & ~l0_sat) l0_wr_cnt <= l0_wr_cnt + 13'd1;
        if (wr_l1 & ~l1_sat) l1_wr_cnt <= l1_wr_cnt + 11'd1;
        if (proto_set)       proto_err <= 1'b1;
      end
      // The select is registered alongside the RAM readback registers.
      if (rb_en) rb_sel_q <= rb_sel;
    end
  end

  conv_host_ram #(.ABITS(AW), .WIDTH(DW)) u_img (
    .clk     (clk),
    .reset   (reset),
    .we      (ld_fire),
    .waddr   (ld_cnt),
    .wdata   (ld_data),
    .raddr   (iaddr),
    .rdata   (idata),
    .rb_en   (1'b0),
    .rb_addr ('0),
    .rb_data (img_rb_unused)
  );

  conv_host_ram #(.ABITS(AW), .WIDTH(DW)) u_l0 (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_l0),
    .waddr   (caddr_wr),
    .wdata   (cdata_wr),
    .raddr   (caddr_rd),
    .rdata   (l0_rdata),
    .rb_en   (rb_en),
    .rb_addr (rb_addr),
    .rb_data (l0_rb)
  );

  conv_host_ram #(.ABITS(L1_AW), .WIDTH(DW)) u_l1 (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_l1),
    .waddr   (caddr_wr[L1_AW-1:0]),
    .wdata   (cdata_wr),
    .raddr   (caddr_rd[L1_AW-1:0]),
    .rdata   (l1_rdata),
    .rb_en   (rb_en),
    .rb_addr (rb_addr[L1_AW-1:0]),
    .rb_data (l1_rb)
  );

  always_comb begin
    cdata_rd = '0;
    if (crd & sel_l0)      cdata_rd = l0_rdata;
    else if (crd & sel_l1) cdata_rd = l1_rdata;
  end

  assign rb_data = rb_sel_q ? l1_rb : l0_rb;

endmodule

// File: tb/tb_conv_host.sv
// tb_conv_host: self-checking bench for conv_host.
// Two hosts share all inputs; the second has a 50-cycle watchdog and sees
// busy stuck high, so it must time out while the first completes normally.
module tb_conv_host;
  import conv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, ld_valid, busy, busy_wd, cwr, crd, rb_sel;
  logic [DW-1:0] ld_data, cdata_wr;
  logic [AW-1:0] iaddr, caddr_wr, caddr_rd, rb_addr;
  logic [2:0]    csel;

  logic          ld_ready, ready, done, timeout, proto_err;
  logic [DW-1:0] idata, cdata_rd, rb_data;
  logic [12:0]   l0_wr_cnt;
  logic [10:0]   l1_wr_cnt;

  logic          wd_ld_ready, wd_ready, wd_done, wd_timeout, wd_proto_err;
  logic [DW-1:0] wd_idata, wd_cdata_rd, wd_rb_data;
  logic [12:0]   wd_l0_wr_cnt;
  logic [10:0]   wd_l1_wr_cnt;

  conv_host dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .csel(csel), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
    .done(done), .timeout(timeout), .proto_err(proto_err),
    .l0_wr_cnt(l0_wr_cnt), .l1_wr_cnt(l1_wr_cnt)
  );

  conv_host #(.MAX_CYC(32'd50)) dut_wd (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(wd_ld_ready), .ready(wd_ready), .busy(busy_wd), .iaddr(iaddr), .idata(wd_idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(wd_cdata_rd), .csel(csel), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(wd_rb_data),
    .done(wd_done), .timeout(wd_timeout), .proto_err(wd_proto_err),
    .l0_wr_cnt(wd_l0_wr_cnt), .l1_wr_cnt(wd_l1_wr_cnt)
  );

  // Reference model: plain arrays plus the run's bookkeeping.
  logic [DW-1:0] img_m [4096];
  logic [DW-1:0] l0_m  [4096];
  logic [DW-1:0] l1_m  [1024];
  int            l0c, l1c;
  bit            perr_m;
  bit            wq_sel  [$];
  logic [AW-1:0] wq_addr [$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int e_cyc;
  logic [DW-1:0] rb_last;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [2:0] sel,
                               input logic [AW-1:0] aw, input logic [AW-1:0] ar,
                               input logic [DW-1:0] dw);
    cwr      = wr;
    crd      = rd;
    csel     = sel;
    caddr_wr = aw;
    caddr_rd = ar;
    cdata_wr = dw;
    #1;
  endtask

  function automatic logic [DW-1:0] expRead(input logic [2:0] sel, input logic [AW-1:0] ar);
    if (sel == 3'b001) return l0_m[ar];
    if (sel == 3'b011) return l1_m[ar & 12'h3FF];
    return '0;
  endfunction

  // Engine access during RUN, described by the protocol rules.
  task automatic modelAccess(input logic wr, input logic rd, input logic [2:0] sel,
                             input logic [AW-1:0] aw, input logic [DW-1:0] dw);
    if (wr && rd) perr_m = 1'b1;
    if (wr) begin
      if (sel == 3'b001) begin
        l0_m[aw] = dw;
        if (l0c == 4096) perr_m = 1'b1; else l0c++;
        wq_sel.push_back(1'b0);
        wq_addr.push_back(aw);
      end else if (sel == 3'b011) begin
        l1_m[aw & 12'h3FF] = dw;
        if (aw >= 12'd1024) perr_m = 1'b1;
        if (l1c == 1024) perr_m = 1'b1; else l1c++;
        wq_sel.push_back(1'b1);
        wq_addr.push_back(aw & 12'h3FF);
      end else begin
        perr_m = 1'b1;
      end
    end
  endtask

  task automatic doAccess(input string tag, input logic wr, input logic rd, input logic [2:0] sel,
                          input logic [AW-1:0] aw, input logic [AW-1:0] ar, input logic [DW-1:0] dw);
    applyStimulus(wr, rd, sel, aw, ar, dw);
    if (rd) checkOutput(tag, cdata_rd, expRead(sel, ar));
    modelAccess(wr, rd, sel, aw, dw);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, '0, '0, '0);
  endtask

  task automatic loadImage(input bit ramp);
    int acc = 0;
    int guard = 0;
    for (int a = 0; a < 4096; a++) img_m[a] = ramp ? 20'(a) : 20'($urandom);
    while (acc < 4096 && guard < 20000) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = img_m[acc];
      tick();
      guard++;
      if (ld_valid) acc++;
      if (acc >= 4095) checkOutput("ready_at_load_end", ready, 32'(acc == 4096));
    end
    ld_valid = 1'b0;
    checkOutput("load_complete", acc, 4096);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ld_ready"},  ld_ready,  0);
    checkOutput({tag, "_ready"},     ready,     0);
    checkOutput({tag, "_done"},      done,      0);
    checkOutput({tag, "_timeout"},   timeout,   0);
    checkOutput({tag, "_proto_err"}, proto_err, 0);
    checkOutput({tag, "_l0_cnt"},    l0_wr_cnt, 0);
    checkOutput({tag, "_l1_cnt"},    l1_wr_cnt, 0);
    checkOutput({tag, "_rb_data"},   rb_data,   0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int k;

    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    busy = 1'b0; busy_wd = 1'b1; iaddr = '0; rb_sel = 1'b0; rb_addr = '0;
    applyStimulus(1'b0, 1'b0, 3'b000, '0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    checkResetValues("reset");

    // ---- Run 1: ramp image, normal completion ----
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("ld_ready_in_load", ld_ready, 1);
    l0c = 0; l1c = 0; perr_m = 1'b0;
    loadImage(1'b1);
    checkOutput("ld_ready_after_load", ld_ready, 0);
    iaddr = 12'h041;
    #1;
    checkOutput("idata_041", idata, img_m[12'h041]);

    tick();
    e_cyc = cyc;
    checkOutput("ready_one_cycle", ready, 0);
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 12'($urandom);
      iaddr = a;
      #1;
      checkOutput("idata_rand", idata, img_m[a]);
    end

    doAccess("l0_wr", 1'b1, 1'b0, 3'b001, 12'h0FF, '0, 20'h13100);
    checkOutput("l0_cnt_first", l0_wr_cnt, 1);
    doAccess("l0_rd_0ff", 1'b0, 1'b1, 3'b001, '0, 12'h0FF, '0);

    for (int i = 0; i < 12; i++) begin
      d = 20'($urandom);
      if ($urandom_range(0, 1) == 1)
        doAccess("rand_wr_l1", 1'b1, 1'b0, 3'b011, 12'($urandom_range(0, 1023)), '0, d);
      else
        doAccess("rand_wr_l0", 1'b1, 1'b0, 3'b001, 12'($urandom), '0, d);
    end
    checkOutput("l0_cnt_rand", l0_wr_cnt, l0c);
    checkOutput("l1_cnt_rand", l1_wr_cnt, l1c);
    checkOutput("proto_clean", proto_err, perr_m);
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, wq_sel.size() - 1);
      if (wq_sel[k])
        doAccess("rand_rd_l1", 1'b0, 1'b1, 3'b011, '0, {2'($urandom), wq_addr[k][9:0]}, '0);
      else
        doAccess("rand_rd_l0", 1'b0, 1'b1, 3'b001, '0, wq_addr[k], '0);
    end
    doAccess("rd_badsel_zero", 1'b0, 1'b1, 3'b010, '0, 12'h0FF, '0);

    d = 20'($urandom);
    doAccess("wr_rd_same_edge", 1'b1, 1'b1, 3'b001, 12'h123, 12'h0FF, d);
    checkOutput("proto_wr_rd", proto_err, perr_m);
    doAccess("wr_rd_landed", 1'b0, 1'b1, 3'b001, '0, 12'h123, '0);

    doAccess("bad_csel_wr", 1'b1, 1'b0, 3'b010, 12'h0FF, '0, 20'h55555);
    checkOutput("proto_bad_csel", proto_err, 1);
    doAccess("bad_csel_nochange", 1'b0, 1'b1, 3'b001, '0, 12'h0FF, '0);
    checkOutput("l0_cnt_bad_csel", l0_wr_cnt, l0c);

    d = 20'($urandom);
    doAccess("l1_alias_wr", 1'b1, 1'b0, 3'b011, 12'h400, '0, d);
    doAccess("l1_alias_rd", 1'b0, 1'b1, 3'b011, '0, 12'h000, '0);
    checkOutput("l1_cnt_alias", l1_wr_cnt, l1c);
    checkOutput("proto_alias", proto_err, perr_m);

    // Watchdog host: 50 RUN cycles after the edge where ready fell.
    while (cyc - e_cyc < 49) tick();
    checkOutput("wd_done_early", wd_done, 0);
    checkOutput("wd_timeout_early", wd_timeout, 0);
    tick();
    checkOutput("wd_done", wd_done, 1);
    checkOutput("wd_timeout", wd_timeout, 1);

    while (cyc - e_cyc < 100) tick();
    busy = 1'b0;
    #1;
    checkOutput("done_before_drop_seen", done, 0);
    tick();
    checkOutput("done_after_busy_fall", done, 1);
    checkOutput("timeout_normal", timeout, 0);
    checkOutput("final_l0_cnt", l0_wr_cnt, l0c);
    checkOutput("final_l1_cnt", l1_wr_cnt, l1c);

    rb_sel = 1'b0;
    rb_addr = 12'h0FF;
    tick();
    checkOutput("rb_l0_0ff", rb_data, l0_m[12'h0FF]);
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, wq_sel.size() - 1);
      rb_sel = wq_sel[k];
      rb_addr = wq_sel[k] ? {2'($urandom), wq_addr[k][9:0]} : wq_addr[k];
      tick();
      checkOutput("rb_rand", rb_data, wq_sel[k] ? l1_m[wq_addr[k][9:0]] : l0_m[wq_addr[k]]);
    end

    // ---- Run 2: random image, readback hold, reset mid-RUN ----
    rb_sel = 1'b0;
    rb_addr = 12'h0FF;
    rb_last = l0_m[12'h0FF];
    start = 1'b1;
    tick();
    start = 1'b0;
    rb_addr = 12'h123;
    checkOutput("run2_ld_ready", ld_ready, 1);
    checkOutput("run2_done_clear", done, 0);
    checkOutput("run2_proto_clear", proto_err, 0);
    checkOutput("run2_l0_clear", l0_wr_cnt, 0);
    checkOutput("run2_l1_clear", l1_wr_cnt, 0);
    checkOutput("run2_wd_timeout_clear", wd_timeout, 0);
    l0c = 0; l1c = 0; perr_m = 1'b0;
    loadImage(1'b0);
    checkOutput("rb_hold_outside_done", rb_data, rb_last);
    tick();
    checkOutput("run2_ready_fell", ready, 0);
    doAccess("pre_reset_bad", 1'b1, 1'b0, 3'b110, 12'h010, '0, 20'h0ABCD);
    doAccess("pre_reset_wr", 1'b1, 1'b0, 3'b001, 12'h010, '0, 20'h0BEEF);
    checkOutput("pre_reset_proto", proto_err, 1);
    checkOutput("pre_reset_l0_cnt", l0_wr_cnt, 1);

    reset = 1'b1;
    tick();
    checkResetValues("mid_run_reset");
    reset = 1'b0;
    tick();
    checkOutput("idle_after_reset", ld_ready, 0);
    for (int i = 0; i < 6; i++) begin
      a = 12'($urandom);
      iaddr = a;
      #1;
      checkOutput("img_after_reset", idata, img_m[a]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_host.md
# conv_host

Host-side responder for the convolution engine's memory protocol. It owns the 64x64 image memory and the layer-0 and layer-1 result memories. It serves the engine's image and layer reads, captures its layer writes, and sequences a run: load the image, pulse `ready`, wait for `busy` to rise and fall, then offer the results for readout. It sits between the engine and the system or test harness.

## Interface
- `DW`, 20, data word width (signed Q4.16 fixed point)
- `AW`, 12, image and layer-0 address width (4096 words)
- `L1_AW`, 10, layer-1 address width (1024 words)
- `MAX_CYC`, 32'd2000000, run watchdog limit in cycles
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to begin load plus run (honoured in IDLE or DONE only)
- `ld_valid`  in  1  image stream word valid
- `ld_data`  in  DW  image stream word, raster order, address 0 first
- `ld_ready`  out  1  high in LOAD
- `ready`  out  1  engine start pulse
- `busy`  in  1  engine busy
- `iaddr`  in  AW  engine image read address
- `idata`  out  DW  image word; combinational from `iaddr`
- `cwr`  in  1  engine layer write strobe
- `caddr_wr`  in  AW  engine write address
- `cdata_wr`  in  DW  engine write data
- `crd`  in  1  engine layer read strobe
- `caddr_rd`  in  AW  engine read address
- `cdata_rd`  out  DW  layer read data; combinational
- `csel`  in  3  memory select: 3'b001 layer 0, 3'b011 layer 1
- `rb_sel`  in  1  readback memory (0: L0, 1: L1)
- `rb_addr`  in  AW  readback address (L1 uses [L1_AW-1:0])
- `rb_data`  out  DW  readback word; registered, 1-cycle latency; valid in DONE
- `done`  out  1  high in DONE
- `timeout`  out  1  sticky; watchdog expired
- `proto_err`  out  1  sticky; illegal access seen
- `l0_wr_cnt`  out  13  layer-0 writes this run
- `l1_wr_cnt`  out  11  layer-1 writes this run

## Operation
- States: IDLE, LOAD, START, RUN, DONE.
  - IDLE/DONE + `start` → LOAD.
  - LOAD → START after the 4096th accepted word (`ld_valid & ld_ready`). The load counter wraps to 0.
  - START: `ready`=1 for exactly one cycle → RUN.
  - RUN: set `busy_seen` on `busy`=1. When `busy_seen & ~busy` → DONE. When the cycle count reaches `MAX_CYC` → set `timeout` → DONE.
- Entering LOAD clears `l0_wr_cnt`, `l1_wr_cnt`, `timeout`, `proto_err`, `busy_seen`, and the cycle counter.
- Image read: `idata = img[iaddr]` in every state. No bounds check; `iaddr` is always in range.
- Layer write: on an edge with `cwr`=1 in RUN:
  - `csel`=001 → `l0[caddr_wr] <= cdata_wr`, `l0_wr_cnt`++.
  - `csel`=011 → `l1[caddr_wr[L1_AW-1:0]] <= cdata_wr`, `l1_wr_cnt`++.
  - Any other `csel` → no write, set `proto_err`.
- Layer read:
  - `cdata_rd = l0[caddr_rd]` when `crd & csel==001`.
  - `cdata_rd = l1[caddr_rd[L1_AW-1:0]]` when `crd & csel==011`.
  - Otherwise 0.
- `proto_err` is also set by:
  - `cwr` or `crd` outside RUN;
  - `cwr & crd` on the same edge (the write still happens);
  - `caddr_wr[AW-1:L1_AW]` != 0 on an L1 write (the write still happens).
- Counters saturate: `l0_wr_cnt` at 4096, `l1_wr_cnt` at 1024. A write beyond saturation also sets `proto_err`.
- `start` outside IDLE/DONE is ignored.
- `busy` high while in IDLE or LOAD is ignored.

## Timing
- Reset values: state IDLE; `ld_ready`, `ready`, `done`, `timeout`, `proto_err` 0; counters 0; `rb_data` 0. `idata` and `cdata_rd` stay combinational. Memory contents are not reset and persist across reset.
- Reset mid-run: the state returns to IDLE at the next edge. The engine is not notified. Layer memories keep any partial data.
- `ready` rises the cycle after the last load word and falls one cycle later.
- The engine raises `busy` the edge after it samples `ready`, so `busy_seen` normally sets 2 cycles after START.
- Write-to-read: a word written on edge N is visible on `cdata_rd`/`idata` combinationally from cycle N+1.
- Readback: `rb_data` is updated on every DONE edge from the `rb_sel`/`rb_addr` sampled at that edge. Outside DONE it holds.
- `done` is registered and rises one cycle after `busy` falls.

## Structure
- Shared package `conv_pkg`:
  - `DW`, `AW`, `L1_AW`;
  - `CSEL_L0`=3'b001, `CSEL_L1`=3'b011;
  - the state enum.
- One sub-module `conv_host_ram`, instantiated three times (image, L0, L1):
  - parameterized depth and width;
  - single write port, async read port, plus a registered read port for readback.

## Test plan
- Load ramp `img[a]=a`, engine model reads `iaddr`=12'h041 → `idata`=20'h00041 in the same cycle.
- `ready` behaviour:
  - `ready` is high for exactly 1 cycle after word 4095.
  - Model raises `busy` 1 cycle later and drops it 100 cycles after that → `done`=1 on the next cycle, `timeout`=0.
- Write then read:
  - `cwr`, `csel`=001, `caddr_wr`=12'h0FF, `cdata_wr`=20'h13100 → `l0_wr_cnt`=1.
  - Next cycle, `crd`, `csel`=001, `caddr_rd`=12'h0FF → `cdata_rd`=20'h13100.
  - In DONE, `rb_sel`=0, `rb_addr`=12'h0FF → `rb_data`=20'h13100 one cycle later.
- Illegal accesses:
  - `cwr` with `csel`=3'b010 → no memory change, `proto_err`=1.
  - `cwr & crd` together → write lands, `proto_err`=1.
  - L1 write with `caddr_wr`=12'h400 → lands at L1 address 0, `proto_err`=1.
- Watchdog: `MAX_CYC`=50, `busy` held high → `timeout`=1 and `done`=1 after 50 RUN cycles.
- Reset asserted mid-RUN → IDLE next cycle, outputs at reset values, image contents intact on re-read.
